// File: rtl/param_register_file.sv
// param_register_file
// Parametrised multi-port register file used as the datapath operand store.
// Combinational read ports feed the ALU operand muxes; the single write port
// is driven from writeback. Optional write-to-read bypass, optional hardwired
// zero register 0, and a multi-cycle clear sequencer that zeroes one entry
// per cycle while ready is low.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; depth is 2**ADDR_W
//   NUM_RD   number of read ports (>= 1)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes
//   BYPASS   1 = a read of the address being written returns write_data
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   we          write enable
//   write_addr  write address
//   write_data  write data
//   read_addr   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   read_data   packed read data, port k at [k*DATA_W +: DATA_W]
//   clear       single-cycle request to zero the whole file
//   ready       high when writes and clear are accepted
module param_register_file #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          write_addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic                       clear,
    output logic                       ready
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                zero_wr_c;
    logic                wr_en_c;

    // ready is a direct decode of the state flop
    assign ready = (state_q == ST_IDLE);

    // Writes to a hardwired-zero register 0 are discarded
    assign zero_wr_c = (ZERO_REG != 0) && (write_addr == '0);

    // clear wins over a same-cycle write; nothing is written during a sweep
    assign wr_en_c = we & ready & ~clear & ~zero_wr_c;

    // State and sweep-pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic for the clear sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Pointer wraps to 0 naturally on the last entry
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage: sweep zeroing and normal writes are mutually exclusive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (state_q == ST_SWEEP) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en_c) begin
            mem_q[write_addr] <= write_data;
        end
    end

    // Independent combinational read lanes
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr_c;
        logic [DATA_W-1:0] rd_data_c;

        assign rd_addr_c = read_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data_c = mem_q[rd_addr_c];
            if ((ZERO_REG != 0) && (rd_addr_c == '0)) begin
                rd_data_c = '0;
            end else if ((BYPASS != 0) && wr_en_c && (rd_addr_c == write_addr)) begin
                rd_data_c = write_data;
            end
        end

        assign read_data[k*DATA_W +: DATA_W] = rd_data_c;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: four instances cover the
// default build, BYPASS=0, ZERO_REG=1 and a wide 4-port/16-bit/16-deep build.
// The three 8x8 instances share stimulus; a randomized phase checks all three
// against a behavioural model of the file.
module tb_param_register_file;

    logic        clk;
    logic        rst;

    // Shared stimulus for the three 8-entry x 8-bit instances
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [5:0]  ra;
    logic        clear;
    logic [15:0] d_rd, n_rd, z_rd;
    logic        d_ready, n_ready, z_ready;

    // Wide instance stimulus
    logic        w_we;
    logic [3:0]  w_wa;
    logic [15:0] w_wd;
    logic [15:0] w_ra;
    logic        w_clear;
    logic [63:0] w_rd;
    logic        w_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model for the randomized phase
    logic [7:0] m_mem [8];
    bit         m_sweeping;
    int         m_sidx;

    param_register_file u_def (
        .clk(clk), .rst(rst), .we(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(d_rd), .clear(clear), .ready(d_ready)
    );

    param_register_file #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(n_rd), .clear(clear), .ready(n_ready)
    );

    param_register_file #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .we(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(z_rd), .clear(clear), .ready(z_ready)
    );

    param_register_file #(.NUM_RD(4), .DATA_W(16), .ADDR_W(4)) u_w (
        .clk(clk), .rst(rst), .we(w_we), .write_addr(w_wa), .write_data(w_wd),
        .read_addr(w_ra), .read_data(w_rd), .clear(w_clear), .ready(w_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single write on the shared 8x8 port
    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we = 1'b0; wa = '0; wd = '0; ra = {3'd7, 3'd5}; clear = 1'b0;
        w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra = 16'h8F31; w_clear = 1'b0;
        #2;
        n_tests++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_d_ready got %b exp 1", d_ready); end
        n_tests++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w_ready got %b exp 1", w_ready); end
        n_tests++; if (d_rd !== 16'h0) begin n_fail++; $display("FAIL reset_d_rd got %h exp 0000", d_rd); end
        n_tests++; if (n_rd !== 16'h0) begin n_fail++; $display("FAIL reset_n_rd got %h exp 0000", n_rd); end
        n_tests++; if (w_rd !== 64'h0) begin n_fail++; $display("FAIL reset_w_rd got %h exp 0", w_rd); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wr8(3'd0, 8'h55);
        wr8(3'd1, 8'hAA);
        ra = {3'd1, 3'd0};
        #1;
        n_tests++; if (d_rd !== 16'hAA55) begin n_fail++; $display("FAIL basic_rd01 got %h exp AA55", d_rd); end
        n_tests++; if (z_rd !== 16'hAA00) begin n_fail++; $display("FAIL basic_zero_rd01 got %h exp AA00", z_rd); end
        ra = {3'd0, 3'd0};
        #1;
        n_tests++; if (d_rd !== 16'h5555) begin n_fail++; $display("FAIL basic_rd00 got %h exp 5555", d_rd); end
    endtask

    task automatic test_bypass();
        wr8(3'd3, 8'h11);
        @(negedge clk);
        we = 1'b1; wa = 3'd3; wd = 8'h22; ra = {3'd0, 3'd3};
        #1;
        n_tests++; if (d_rd[7:0] !== 8'h22) begin n_fail++; $display("FAIL bypass_on_pre got %h exp 22", d_rd[7:0]); end
        n_tests++; if (n_rd[7:0] !== 8'h11) begin n_fail++; $display("FAIL bypass_off_pre got %h exp 11", n_rd[7:0]); end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        n_tests++; if (n_rd[7:0] !== 8'h22) begin n_fail++; $display("FAIL bypass_off_post got %h exp 22", n_rd[7:0]); end
        n_tests++; if (d_rd[7:0] !== 8'h22) begin n_fail++; $display("FAIL bypass_on_post got %h exp 22", d_rd[7:0]); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; wa = 3'd0; wd = 8'hFF; ra = {3'd0, 3'd0};
        #1;
        n_tests++; if (z_rd !== 16'h0000) begin n_fail++; $display("FAIL zero_pre got %h exp 0000", z_rd); end
        n_tests++; if (d_rd !== 16'hFFFF) begin n_fail++; $display("FAIL zero_default_bypass got %h exp FFFF", d_rd); end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        n_tests++; if (z_rd !== 16'h0000) begin n_fail++; $display("FAIL zero_post got %h exp 0000", z_rd); end
        wr8(3'd7, 8'hFF);
        ra = {3'd7, 3'd7};
        #1;
        n_tests++; if (z_rd !== 16'hFFFF) begin n_fail++; $display("FAIL zero_addr7 got %h exp FFFF", z_rd); end
    endtask

    task automatic test_clear_sweep();
        int low;
        for (int i = 0; i < 8; i++) wr8(3'(i), 8'(8'h80 + i));
        ra = {3'd7, 3'd0};
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        low = 0;
        while (d_ready == 1'b0 && low < 40) begin
            low++;
            if (low == 2) begin
                n_tests++; if (d_rd !== 16'h8700) begin n_fail++; $display("FAIL sweep_partial got %h exp 8700", d_rd); end
                we = 1'b1; wa = 3'd2; wd = 8'h33;
                #1;
                n_tests++; if (n_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_nb_ready got %b exp 0", n_ready); end
            end
            if (low == 3) we = 1'b0;
            @(posedge clk);
            #1;
        end
        n_tests++; if (low !== 8) begin n_fail++; $display("FAIL sweep_ready_low got %0d cycles exp 8", low); end
        for (int p = 0; p < 8; p += 2) begin
            ra = {3'(p + 1), 3'(p)};
            #1;
            n_tests++; if (d_rd !== 16'h0) begin n_fail++; $display("FAIL sweep_zero_d addr %0d got %h exp 0000", p, d_rd); end
            n_tests++; if (z_rd !== 16'h0) begin n_fail++; $display("FAIL sweep_zero_z addr %0d got %h exp 0000", p, z_rd); end
        end
    endtask

    task automatic test_clear_we();
        int cyc;
        @(negedge clk);
        clear = 1'b1; we = 1'b1; wa = 3'd4; wd = 8'h44; ra = {3'd4, 3'd4};
        #1;
        n_tests++; if (d_rd !== 16'h0) begin n_fail++; $display("FAIL clear_we_nobypass got %h exp 0000", d_rd); end
        @(posedge clk);
        #1;
        clear = 1'b0; we = 1'b0;
        n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL clear_we_ready got %b exp 0", d_ready); end
        cyc = 0;
        while (d_ready == 1'b0 && cyc < 40) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        n_tests++; if (cyc !== 8) begin n_fail++; $display("FAIL clear_we_ready_low got %0d exp 8", cyc); end
        n_tests++; if (d_rd !== 16'h0) begin n_fail++; $display("FAIL clear_we_addr4 got %h exp 0000", d_rd); end
    endtask

    task automatic test_reset_mid_sweep();
        wr8(3'd6, 8'h99);
        wr8(3'd7, 8'h99);
        ra = {3'd7, 3'd6};
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (d_rd !== 16'h9999) begin n_fail++; $display("FAIL rst_sweep_pre got %h exp 9999", d_rd); end
        rst = 1'b1;
        #1;
        n_tests++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sweep_ready got %b exp 1", d_ready); end
        n_tests++; if (d_rd !== 16'h0) begin n_fail++; $display("FAIL rst_sweep_rd got %h exp 0000", d_rd); end
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sweep_ready_after got %b exp 1", d_ready); end
        wr8(3'd5, 8'h5A);
        ra = {3'd5, 3'd5};
        #1;
        n_tests++; if (d_rd !== 16'h5A5A) begin n_fail++; $display("FAIL rst_sweep_write got %h exp 5A5A", d_rd); end
    endtask

    task automatic test_wide();
        int low;
        @(negedge clk);
        w_we = 1'b1; w_wa = 4'd15; w_wd = 16'hBEEF;
        @(posedge clk);
        #1;
        w_we = 1'b0;
        w_ra = {4{4'hF}};
        #1;
        n_tests++; if (w_rd !== {4{16'hBEEF}}) begin n_fail++; $display("FAIL wide_read got %h exp %h", w_rd, {4{16'hBEEF}}); end
        @(negedge clk);
        w_clear = 1'b1;
        @(posedge clk);
        #1;
        w_clear = 1'b0;
        low = 0;
        while (w_ready == 1'b0 && low < 60) begin
            low++;
            @(posedge clk);
            #1;
        end
        n_tests++; if (low !== 16) begin n_fail++; $display("FAIL wide_ready_low got %0d exp 16", low); end
        n_tests++; if (w_rd !== 64'h0) begin n_fail++; $display("FAIL wide_cleared got %h exp 0", w_rd); end
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [7:0] ed, en, ez;
        bit         wr;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        we = 1'b0; clear = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_sweeping = 1'b0;
        m_sidx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            we    = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 19) == 0);
            wa    = 3'($urandom);
            wd    = 8'($urandom);
            ra    = 6'($urandom);
            #1;
            wr = we && !m_sweeping && !clear;
            n_tests++;
            if (d_ready !== !m_sweeping) begin
                n_fail++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, d_ready, !m_sweeping);
            end
            for (int k = 0; k < 2; k++) begin
                a  = ra[k*3 +: 3];
                en = m_mem[a];
                ed = (wr && a == wa) ? wd : m_mem[a];
                ez = (a == 3'd0) ? 8'h00 : ed;
                n_tests++;
                if (d_rd[k*8 +: 8] !== ed) begin
                    n_fail++; $display("FAIL rand_def cyc %0d lane %0d got %h exp %h", cyc, k, d_rd[k*8 +: 8], ed);
                end
                n_tests++;
                if (n_rd[k*8 +: 8] !== en) begin
                    n_fail++; $display("FAIL rand_nobypass cyc %0d lane %0d got %h exp %h", cyc, k, n_rd[k*8 +: 8], en);
                end
                n_tests++;
                if (z_rd[k*8 +: 8] !== ez) begin
                    n_fail++; $display("FAIL rand_zero cyc %0d lane %0d got %h exp %h", cyc, k, z_rd[k*8 +: 8], ez);
                end
            end
            // Effect of the coming edge on the model
            if (m_sweeping) begin
                m_mem[m_sidx] = 8'h00;
                m_sidx++;
                if (m_sidx == 8) m_sweeping = 1'b0;
            end else if (clear) begin
                m_sweeping = 1'b1;
                m_sidx = 0;
            end else if (wr) begin
                m_mem[wa] = wd;
            end
        end
        @(negedge clk);
        we = 1'b0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_clear_sweep();
        test_clear_we();
        test_reset_mid_sweep();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
